store_buffer: RTL

- Posted-write buffer between the pipelined core's MEM stage and the word-wide data memory.
- Absorbs stores (SB/SH/SW) into a small FIFO and drains them to memory one per accepted cycle.
- Loads read memory combinationally. Buffered bytes for the same word are merged in, youngest entry wins, so the core always sees program-order data.
- Performs dm_ctrl byte-lane alignment on stores and sign/zero extension on loads, so the core's Data_in is ready to use.

---
 rtl/store_buffer_pkg.sv | 22 ++
 rtl/sb_lane_align.sv | 54 +++++
 rtl/store_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared encodings and entry layout for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned WordAddrW = 30;
  localparam int unsigned DataW     = 32;
  localparam int unsigned BeW       = 4;

  typedef enum logic [2:0] {
    DmWord             = 3'b000,
    DmHalfword         = 3'b001,
    DmHalfwordUnsigned = 3'b010,
    DmByte             = 3'b011,
    DmByteUnsigned     = 3'b100
  } dm_ctrl_e;

  typedef struct packed {
    logic [WordAddrW-1:0] waddr;
    logic [DataW-1:0]     data;
    logic [BeW-1:0]       be;
  } sb_entry_t;

endpackage

// File: rtl/sb_lane_align.sv
// Byte-lane alignment: store-side be/replicated data, or load-side lane select plus extension.
module sb_lane_align
  import store_buffer_pkg::*;
#(
  parameter bit Load = 1'b0
) (
  input  logic [1:0]       addr_lo_i,
  input  logic [2:0]       dm_ctrl_i,
  input  logic [DataW-1:0] data_i,
  output logic [BeW-1:0]   be_o,
  output logic [DataW-1:0] data_o,
  output logic             misalign_o
);

  logic [1:0]       off;
  logic [DataW-1:0] shifted;
  logic [DataW-1:0] st_data;
  logic [DataW-1:0] ld_data;

  always_comb begin
    be_o       = 4'b1111;
    off        = 2'b00;
    misalign_o = 1'b0;
    st_data    = data_i;
    ld_data    = data_i;
    // Misaligned accesses drop the low offset bit(s) rather than straddling words.
    case (dm_ctrl_i)
      DmHalfword, DmHalfwordUnsigned: begin
        off        = {addr_lo_i[1], 1'b0};
        be_o       = 4'b0011 << off;
        misalign_o = addr_lo_i[0];
        st_data    = {2{data_i[15:0]}};
      end
      DmByte, DmByteUnsigned: begin
        off     = addr_lo_i;
        be_o    = 4'b0001 << off;
        st_data = {4{data_i[7:0]}};
      end
      default: misalign_o = (addr_lo_i != 2'b00);
    endcase

    shifted = data_i >> {off, 3'b000};
    case (dm_ctrl_i)
      DmHalfword:         ld_data = {{16{shifted[15]}}, shifted[15:0]};
      DmHalfwordUnsigned: ld_data = {16'h0000, shifted[15:0]};
      DmByte:             ld_data = {{24{shifted[7]}}, shifted[7:0]};
      DmByteUnsigned:     ld_data = {24'h000000, shifted[7:0]};
      default:            ld_data = data_i;
    endcase

    data_o = Load ? ld_data : st_data;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory, with store-to-load byte forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [DataW-1:0]     cpu_wdata_i,
  input  logic [2:0]           cpu_dm_ctrl_i,
  output logic [DataW-1:0]     cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 misalign_o,
  output logic                 sb_empty_o,
  input  logic                 drain_req_i,
  output logic [WordAddrW-1:0] mem_raddr_o,
  input  logic [DataW-1:0]     mem_rdata_i,
  output logic                 mem_we_o,
  output logic [WordAddrW-1:0] mem_waddr_o,
  output logic [DataW-1:0]     mem_wdata_o,
  output logic [BeW-1:0]       mem_be_o,
  input  logic                 mem_ready_i
);

  sb_entry_t        entries_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;
  logic             misalign_q, misalign_d;

  logic [BeW-1:0]   st_be;
  logic [DataW-1:0] st_data;
  logic             st_mis;
  logic [DataW-1:0] fwd_word;
  logic [PtrW-1:0]  fwd_idx;
  logic [DataW-1:0] ld_data;
  logic             ld_mis;
  logic [BeW-1:0]   unused_ld_be;
  logic             full, push, pop;

  sb_lane_align #(.Load(1'b0)) u_store_align (
    .addr_lo_i  (cpu_addr_i[1:0]),
    .dm_ctrl_i  (cpu_dm_ctrl_i),
    .data_i     (cpu_wdata_i),
    .be_o       (st_be),
    .data_o     (st_data),
    .misalign_o (st_mis)
  );

  sb_lane_align #(.Load(1'b1)) u_load_align (
    .addr_lo_i  (cpu_addr_i[1:0]),
    .dm_ctrl_i  (cpu_dm_ctrl_i),
    .data_i     (fwd_word),
    .be_o       (unused_ld_be),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  assign sb_empty_o  = (count_q == '0);
  assign full        = (count_q == (PtrW+1)'(Depth));
  // A simultaneous pop frees the slot, so a full buffer only stalls when memory is not ready.
  assign cpu_stall_o = cpu_we_i & ((full & ~mem_ready_i) | (drain_req_i & ~sb_empty_o));
  assign push        = cpu_we_i & ~st_mis & ~cpu_stall_o;
  assign pop         = mem_we_o & mem_ready_i;

  assign mem_we_o    = ~sb_empty_o;
  assign mem_waddr_o = entries_q[head_q].waddr;
  assign mem_wdata_o = entries_q[head_q].data;
  assign mem_be_o    = entries_q[head_q].be;
  assign mem_raddr_o = cpu_addr_i[31:2];
  assign cpu_rdata_o = ld_data;
  assign misalign_o  = misalign_q;

  // Walk oldest to youngest so later stores overwrite earlier ones lane by lane.
  always_comb begin
    fwd_word = mem_rdata_i;
    fwd_idx  = head_q;
    for (int unsigned k = 0; k < Depth; k++) begin
      fwd_idx = head_q + PtrW'(k);
      if (valid_q[fwd_idx] && (entries_q[fwd_idx].waddr == cpu_addr_i[31:2])) begin
        for (int unsigned b = 0; b < BeW; b++) begin
          if (entries_q[fwd_idx].be[b]) begin
            fwd_word[8*b +: 8] = entries_q[fwd_idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    misalign_d = cpu_we_i ? st_mis : ld_mis;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      entries_q[tail_q] <= '{waddr: cpu_addr_i[31:2], data: st_data, be: st_be};
    end
  end

endmodule
